// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI accelerometer poller: FSM states, axis
// selection, the read command byte, axis register addresses and the hex font.
package spi_master_pkg;

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_READ, ST_GAP} state_t;
  typedef enum logic [1:0] {AX_X, AX_Y, AX_Z} axis_t;

  localparam logic [7:0] SPI_CMD_READ = 8'h0B;
  localparam logic [7:0] ADDR_X       = 8'h08;
  localparam logic [7:0] ADDR_Y       = 8'h09;
  localparam logic [7:0] ADDR_Z       = 8'h0A;

  function automatic logic [7:0] axis_addr(input axis_t a);
    case (a)
      AX_Y:    return ADDR_Y;
      AX_Z:    return ADDR_Z;
      default: return ADDR_X;
    endcase
  endfunction

  function automatic axis_t axis_next(input axis_t a);
    case (a)
      AX_X:    return AX_Y;
      AX_Y:    return AX_Z;
      default: return AX_X;
    endcase
  endfunction

  // Active-low segment pattern ordered {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h08;
      4'hB:    return 7'h03;
      4'hC:    return 7'h46;
      4'hD:    return 7'h21;
      4'hE:    return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/seg7_mux.sv
// Two-digit hex display driver: alternates an[0] (low nibble) and an[1] (high
// nibble) every REFRESH_CNT clocks. Only built when SPI_DISPLAY_EN is defined.
`ifdef SPI_DISPLAY_EN
module seg7_mux
  import spi_master_pkg::*;
#(
  parameter int REFRESH_CNT = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_byte,
  output logic [6:0] o_seg,
  output logic [3:0] o_an
);

  localparam int CNT_W = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CNT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_digit;
  logic [3:0]       w_nibble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_digit <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt   <= '0;
      r_digit <= ~r_digit;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_nibble = r_digit ? i_byte[7:4] : i_byte[3:0];
  assign o_seg    = hex_to_seg(w_nibble);
  assign o_an     = r_digit ? 4'b1101 : 4'b1110;

endmodule
`endif

// File: rtl/spi_master.sv
// SPI mode-0 master polling X/Y/Z accelerometer registers (cmd 0x0B, addr, read).
// Define SPI_DISPLAY_EN to drive the captured byte onto a two-digit 7-segment display.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV     = 10,
  parameter int GAP_CYCLES  = 16,
  parameter int REFRESH_CNT = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       active_btn,
  input  logic       miso,
  output logic       mosi,
  output logic       cs,
  output logic       sclk,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dpx,
  output logic       dpy,
  output logic       dpz,
  output logic       rx_debug
);

  localparam int HALF  = CLK_DIV / 2;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(HALF);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(HALF - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  axis_t            r_axis;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit;
  logic [GAP_W-1:0] r_gap;
  logic [7:0]       r_tx, r_rx, r_disp;
  logic [2:0]       r_dp;
  logic             w_active, w_period_end, w_byte_end;

  assign w_active     = (r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_READ);
  assign w_period_end = w_active && (r_div == DIV_LAST);
  assign w_byte_end   = w_period_end && (r_bit == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (active_btn) w_state_nxt = ST_CMD;
      ST_CMD:  if (w_byte_end) w_state_nxt = ST_ADDR;
      ST_ADDR: if (w_byte_end) w_state_nxt = ST_READ;
      ST_READ: if (w_byte_end) w_state_nxt = ST_GAP;
      ST_GAP:  if (r_gap == GAP_LAST) w_state_nxt = active_btn ? ST_CMD : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Low half of each SCLK period first, so the falling edge coincides with the shift
  always_comb begin
    cs       = 1'b1;
    sclk     = 1'b0;
    mosi     = 1'b0;
    rx_debug = (r_state == ST_READ);
    if (w_active) begin
      cs   = 1'b0;
      sclk = (r_div >= DIV_HALF);
      mosi = r_tx[7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_bit  <= '0;
      r_gap  <= '0;
      r_tx   <= '0;
      r_rx   <= '0;
      r_axis <= AX_X;
      r_disp <= '0;
      r_dp   <= '0;
    end else begin
      if (w_active) begin
        r_div <= w_period_end ? '0 : r_div + 1'b1;
        if (w_period_end) begin
          r_bit <= r_bit + 1'b1;
          if (w_byte_end && (r_state == ST_CMD)) r_tx <= axis_addr(r_axis);
          else                                   r_tx <= {r_tx[6:0], 1'b0};
        end
        // Sample on the edge where sclk is about to rise
        if ((r_state == ST_READ) && (r_div == DIV_RISE)) r_rx <= {r_rx[6:0], miso};
      end else begin
        r_div <= '0;
        r_bit <= '0;
        r_tx  <= SPI_CMD_READ;
      end
      r_gap <= (r_state == ST_GAP) ? r_gap + 1'b1 : '0;
      if ((r_state == ST_READ) && w_byte_end) begin
        r_disp <= r_rx;
        r_dp   <= 3'b001 << r_axis;
        r_axis <= axis_next(r_axis);
      end
    end
  end

  assign dpx = r_dp[0];
  assign dpy = r_dp[1];
  assign dpz = r_dp[2];

`ifdef SPI_DISPLAY_EN
  seg7_mux #(
    .REFRESH_CNT(REFRESH_CNT)
  ) u_seg7 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_byte(r_disp),
    .o_seg (seg),
    .o_an  (an)
  );
`else
  localparam int unused_refresh_cnt = REFRESH_CNT;
  logic w_unused_disp;
  assign w_unused_disp = ^r_disp;
  assign seg = 7'h7F;
  assign an  = 4'hF;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: table of polled transactions plus reset/idle/abort sequences.
module tb_spi_master;

  localparam int REFRESH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       active_btn = 1'b0;
  logic       miso = 1'b0;
  logic       mosi, cs, sclk, dpx, dpy, dpz, rx_debug;
  logic [6:0] seg;
  logic [3:0] an;

  spi_master #(
    .CLK_DIV(10), .GAP_CYCLES(16), .REFRESH_CNT(REFRESH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .active_btn(active_btn), .miso(miso),
    .mosi(mosi), .cs(cs), .sclk(sclk), .seg(seg), .an(an),
    .dpx(dpx), .dpy(dpy), .dpz(dpz), .rx_debug(rx_debug)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor and slave model, both sampled on the falling clk edge
  logic [7:0]  slave_byte = 8'h00;
  logic [2:0]  rk;
  int          starts, dones, lowc, highc, rises, rxc, gapc, sclk_bad, rx_bad, rx_pulses;
  logic [23:0] mosi_sh;
  logic [23:0] rec_mosi[8];
  int          rec_low[8], rec_high[8], rec_rises[8], rec_rx[8], rec_gap[8];
  logic        p_cs = 1'b1, p_sclk = 1'b0, p_rx = 1'b0;

  always @(negedge clk) begin
    if (cs || !rx_debug) begin
      rk   = 3'd0;
      miso = slave_byte[7];
    end else if (sclk && !p_sclk) begin
      rk   = rk + 3'd1;
      miso = slave_byte[3'd7 - rk];
    end
    if (!rst_n) begin
      starts = 0; dones = 0; lowc = 0; highc = 0; rises = 0; rxc = 0; gapc = 0;
      sclk_bad = 0; rx_bad = 0; rx_pulses = 0; mosi_sh = '0;
      p_cs = 1'b1; p_sclk = 1'b0; p_rx = 1'b0;
    end else begin
      if (!cs) begin
        if (p_cs) begin
          mosi_sh = '0; lowc = 0; highc = 0; rises = 0; rxc = 0;
          if (starts < 8) rec_gap[starts] = gapc;
          starts++;
        end
        lowc++;
        if (sclk) highc++;
        if (rx_debug) rxc++;
        if (sclk && !p_sclk) begin
          mosi_sh = {mosi_sh[22:0], mosi};
          rises++;
        end
      end else begin
        if (!p_cs) begin
          if (dones < 8) begin
            rec_mosi[dones] = mosi_sh; rec_low[dones] = lowc; rec_high[dones] = highc;
            rec_rises[dones] = rises; rec_rx[dones] = rxc;
          end
          dones++;
          gapc = 0;
        end
        gapc++;
        if (sclk) sclk_bad++;
        if (rx_debug) rx_bad++;
      end
      if (rx_debug && !p_rx) rx_pulses++;
      p_cs = cs; p_sclk = sclk; p_rx = rx_debug;
    end
  end

  task automatic check_display(input string tag, input logic [6:0] lo, input logic [6:0] hi);
`ifdef SPI_DISPLAY_EN
    logic [6:0] s_lo, s_hi;
    int bad_an;
    s_lo = '1; s_hi = '1; bad_an = 0;
    for (int k = 0; k < 4 * REFRESH + 4; k++) begin
      @(negedge clk);
      if (an == 4'b1110) s_lo = seg;
      else if (an == 4'b1101) s_hi = seg;
      else bad_an++;
    end
    check({tag, "_seg_lo"}, 32'(s_lo), 32'(lo));
    check({tag, "_seg_hi"}, 32'(s_hi), 32'(hi));
    check({tag, "_an_onehot"}, bad_an, 0);
`else
    check({tag, "_seg_off"}, 32'(seg), 32'h7F);
    check({tag, "_an_off"}, 32'(an), 32'hF);
    check({tag, "_font_ref"}, 32'(lo | hi), 32'(lo | hi));
`endif
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] slave;
    logic [7:0] addr;
    logic [2:0] dp;
    logic [6:0] seg_lo;
    logic [6:0] seg_hi;
    logic       drop;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'h55, 8'h08, 3'b001, 7'h12, 7'h12, 1'b0};
    vecs[1] = '{8'hA3, 8'h09, 3'b010, 7'h30, 7'h08, 1'b0};
    vecs[2] = '{8'h0F, 8'h0A, 3'b100, 7'h0E, 7'h40, 1'b0};
    vecs[3] = '{8'hB6, 8'h08, 3'b001, 7'h02, 7'h03, 1'b0};
    vecs[4] = '{8'hD9, 8'h09, 3'b010, 7'h10, 7'h21, 1'b1};

    // Reset state held while rst_n is low
    wait_cycles(3);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_rxdbg", 32'(rx_debug), 32'd0);
    check("rst_dp", 32'({dpz, dpy, dpx}), 32'd0);
`ifdef SPI_DISPLAY_EN
    check("rst_an", 32'(an), 32'hE);
    check("rst_seg", 32'(seg), 32'h40);
`else
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
`endif
    rst_n = 1'b1;

    // Idle with polling disabled
    wait_cycles(200);
    check("idle_no_cs", starts, 0);
    check("idle_sclk", sclk_bad, 0);
    check("idle_rxdbg", rx_bad, 0);

    // Continuous polling through the vector table
    active_btn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 1000 && !(starts > i); k++) @(negedge clk);
      check($sformatf("t%0d_started", i), 32'(starts > i), 32'd1);
      slave_byte = vecs[i].slave;
      if (vecs[i].drop) begin
        for (int k = 0; k < 300 && lowc < 100; k++) @(negedge clk);
        check($sformatf("t%0d_in_addr", i), 32'(lowc >= 100 && lowc < 160), 32'd1);
        active_btn = 1'b0;
      end
      for (int k = 0; k < 1000 && !(dones > i); k++) @(negedge clk);
      check($sformatf("t%0d_done", i), 32'(dones > i), 32'd1);
      wait_cycles(3);
      check($sformatf("t%0d_mosi", i), 32'(rec_mosi[i]), 32'({8'h0B, vecs[i].addr, 8'h00}));
      check($sformatf("t%0d_cs_low", i), rec_low[i], 240);
      check($sformatf("t%0d_rises", i), rec_rises[i], 24);
      check($sformatf("t%0d_sclk_high", i), rec_high[i], 120);
      check($sformatf("t%0d_rx_len", i), rec_rx[i], 80);
      if (i > 0) check($sformatf("t%0d_gap", i), rec_gap[i], 16);
      check($sformatf("t%0d_disp", i), 32'(dut.r_disp), 32'(vecs[i].slave));
      check($sformatf("t%0d_dp", i), 32'({dpz, dpy, dpx}), 32'(vecs[i].dp));
      check_display($sformatf("t%0d", i), vecs[i].seg_lo, vecs[i].seg_hi);
    end

    // After the mid-ADDR drop, the bus stays quiet
    wait_cycles(300);
    check("drop_no_restart", starts, 5);
    check("drop_cs_high", 32'(cs), 32'd1);
    check("rx_pulses", rx_pulses, 5);
    check("sclk_when_cs_high", sclk_bad, 0);

    // Fresh start, one capture, then reset in the middle of the next READ
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    slave_byte = 8'h3C;
    active_btn = 1'b1;
    for (int k = 0; k < 1000 && dones < 1; k++) @(negedge clk);
    check("r1_done", 32'(dones >= 1), 32'd1);
    wait_cycles(2);
    check("r1_mosi", 32'(rec_mosi[0]), 32'h0B0800);
    check("r1_disp", 32'(dut.r_disp), 32'h3C);
    check("r1_dp", 32'({dpz, dpy, dpx}), 32'b001);
    for (int k = 0; k < 1000 && !rx_debug; k++) @(negedge clk);
    check("r2_in_read", 32'(rx_debug), 32'd1);
    wait_cycles(20);
    rst_n = 1'b0;
    #1;
    check("abort_cs", 32'(cs), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_rxdbg", 32'(rx_debug), 32'd0);
    check("abort_mosi", 32'(mosi), 32'd0);
    check("abort_dp", 32'({dpz, dpy, dpx}), 32'd0);
    check("abort_disp", 32'(dut.r_disp), 32'h00);
    wait_cycles(2);
    rst_n = 1'b1;
    slave_byte = 8'h7E;
    for (int k = 0; k < 1000 && dones < 1; k++) @(negedge clk);
    check("r3_done", 32'(dones >= 1), 32'd1);
    wait_cycles(2);
    check("r3_mosi_axis_x", 32'(rec_mosi[0]), 32'h0B0800);
    check("r3_disp", 32'(dut.r_disp), 32'h7E);
    check("r3_dp", 32'({dpz, dpy, dpx}), 32'b001);
    active_btn = 1'b0;
    wait_cycles(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
